// File: rtl/ap_divi_pkg.sv
// Shared constants for the ap_divi iterative divider.
// State encoding and the iteration-counter width helper.
package ap_pkg;

    typedef enum logic [1:0] {
        AP_DIV_IDLE = 2'd0,
        AP_DIV_RUN  = 2'd1,
        AP_DIV_DONE = 2'd2
    } ap_div_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/ap_divi_step.sv
// One radix-2 restoring division step: shift {rem,quot} left,
// trial-subtract the divisor and keep the difference when it fits.
module ap_divi_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quot,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH-1:0] rem_nx,
    output logic [WIDTH-1:0] quot_nx
);

    logic [WIDTH-1:0] sh;
    logic             ge;

    always_comb begin
        sh = {rem[WIDTH-2:0], quot[WIDTH-1]};
        // the bit shifted out of rem makes the trial value exceed any divisor
        ge = rem[WIDTH-1] | (sh >= div);
        rem_nx = ge ? (sh - div) : sh;
        quot_nx = {quot[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/ap_divi.sv
// Multi-cycle restoring integer divider with start/ready handshake.
// Define AP_DIVI_SIGNED_EN for two's-complement truncating division.
module ap_divi
    import ap_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] c_out,
    output logic [WIDTH-1:0] r_out,
    output logic             ready_out,
    output logic             busy_out
);

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    ap_div_state_t    state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quot_nx;
    logic [WIDTH-1:0] a_op;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] c_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef AP_DIVI_SIGNED_EN
    logic neg_q;
    logic neg_r;

    // MIN has no positive magnitude but reads correctly as unsigned
    assign a_op  = a_in[WIDTH-1] ? -a_in : a_in;
    assign b_op  = b_in[WIDTH-1] ? -b_in : b_in;
    assign c_fix = neg_q ? -quot_nx : quot_nx;
    assign r_fix = neg_r ? -rem_nx : rem_nx;
`else
    assign a_op  = a_in;
    assign b_op  = b_in;
    assign c_fix = quot_nx;
    assign r_fix = rem_nx;
`endif

    ap_divi_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem    (rem),
        .quot   (quot),
        .div    (div),
        .rem_nx (rem_nx),
        .quot_nx(quot_nx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= AP_DIV_IDLE;
            cnt       <= '0;
            rem       <= '0;
            quot      <= '0;
            div       <= '0;
            c_out     <= '0;
            r_out     <= '0;
            ready_out <= 1'b0;
            busy_out  <= 1'b0;
`ifdef AP_DIVI_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            unique case (state)
                AP_DIV_IDLE, AP_DIV_DONE: begin
                    ready_out <= 1'b0;
                    if (start_in) begin
                        rem      <= '0;
                        quot     <= a_op;
                        div      <= b_op;
                        cnt      <= CW'(WIDTH - 1);
                        busy_out <= 1'b1;
                        state    <= AP_DIV_RUN;
`ifdef AP_DIVI_SIGNED_EN
                        neg_q    <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
                        neg_r    <= a_in[WIDTH-1];
`endif
                    end else begin
                        state <= AP_DIV_IDLE;
                    end
                end
                AP_DIV_RUN: begin
                    rem  <= rem_nx;
                    quot <= quot_nx;
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0) begin
                        c_out     <= c_fix;
                        r_out     <= r_fix;
                        busy_out  <= 1'b0;
                        ready_out <= 1'b1;
                        state     <= AP_DIV_DONE;
                    end
                end
                default: begin
                    state <= AP_DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ap_divi.sv
// Self-checking bench for ap_divi (WIDTH=32).
// Build with AP_DIVI_SIGNED_EN to exercise the signed variant.
module tb_ap_divi;

    localparam int W   = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start_in = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic [W-1:0] c_out;
    logic [W-1:0] r_out;
    logic         ready_out;
    logic         busy_out;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ap_divi #(
        .WIDTH(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start_in (start_in),
        .a_in     (a_in),
        .b_in     (b_in),
        .c_out    (c_out),
        .r_out    (r_out),
        .ready_out(ready_out),
        .busy_out (busy_out)
    );

    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    output logic [W-1:0] c, output logic [W-1:0] r);
`ifdef AP_DIVI_SIGNED_EN
        longint sa, sb, q, m;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (b == '0) begin
            c = (sa >= 0) ? '1 : W'(1);
            r = a;
        end else begin
            q = sa / sb;
            m = sa % sb;
            c = q[W-1:0];
            r = m[W-1:0];
        end
`else
        if (b == '0) begin
            c = '1;
            r = a;
        end else begin
            c = a / b;
            r = a % b;
        end
`endif
    endfunction

    // Issue one single-cycle start, then watch busy/ready until the result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] c, output logic [W-1:0] r,
                          output int lat, output int busy_bad);
        @(negedge clk);
        a_in = a;
        b_in = b;
        start_in = 1'b1;
        lat = -1;
        busy_bad = 0;
        c = 'x;
        r = 'x;
        for (int k = 1; k <= LAT + 5; k++) begin
            @(negedge clk);
            if (ready_out === 1'b1) begin
                lat = k;
                c = c_out;
                r = r_out;
                if (busy_out !== 1'b0) busy_bad++;
                break;
            end
            if (busy_out !== (k <= W)) busy_bad++;
            if (k == 1) begin
                start_in = 1'b0;
                a_in = $urandom;
                b_in = $urandom;
            end
        end
        start_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [W-1:0] c, r;
        int lat, bb;
        int bad;
        #2;
        checks++;
        if ({c_out, r_out, ready_out, busy_out} !== '0) begin
            failures++;
            $display("FAIL reset_hold got c=%h r=%h rdy=%b busy=%b want all 0",
                     c_out, r_out, ready_out, busy_out);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (ready_out !== 1'b0 || busy_out !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL reset_idle got %0d cycles with rdy/busy high want 0", bad);
        end
        run_op(32'd100, 32'd7, c, r, lat, bb);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({c_out, r_out, ready_out, busy_out} !== '0) begin
            failures++;
            $display("FAIL reset_async got c=%h r=%h rdy=%b busy=%b want all 0",
                     c_out, r_out, ready_out, busy_out);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [W-1:0] c, r;
        int lat, bb;
        run_op(32'd100, 32'd7, c, r, lat, bb);
        checks++;
        if (lat != LAT) begin
            failures++;
            $display("FAIL basic_latency got %0d want %0d", lat, LAT);
        end
        checks++;
        if (bb != 0) begin
            failures++;
            $display("FAIL basic_busy got %0d bad cycles want 0", bb);
        end
        checks++;
        if (c !== 32'd14) begin
            failures++;
            $display("FAIL basic_quot got %0d want 14", c);
        end
        checks++;
        if (r !== 32'd2) begin
            failures++;
            $display("FAIL basic_rem got %0d want 2", r);
        end
    endtask

    task automatic test_edges();
        logic [W-1:0] ta [3] = '{32'hFFFF_FFFF, 32'd5, 32'd123};
        logic [W-1:0] tb [3] = '{32'd1, 32'd9, 32'd0};
        logic [W-1:0] tc [3] = '{32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF};
        logic [W-1:0] tr [3] = '{32'd0, 32'd5, 32'd123};
        logic [W-1:0] c, r;
        int lat, bb;
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], c, r, lat, bb);
            checks++;
            if (c !== tc[i] || r !== tr[i] || lat != LAT) begin
                failures++;
                $display("FAIL edge_%0d got c=%h r=%h lat=%0d want c=%h r=%h lat=%0d",
                         i, c, r, lat, tc[i], tr[i], LAT);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, c, r, ec, er;
        int lat, bb;
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = W'($urandom_range(1, 255));
                2: b = {{(W-8){b_in[0]}}, 8'($urandom_range(1, 255))};
                default: b = (i == 15) ? '0 : W'($urandom_range(1, 65535));
            endcase
            ref_div(a, b, ec, er);
            run_op(a, b, c, r, lat, bb);
            checks++;
            if (c !== ec || r !== er || lat != LAT || bb != 0) begin
                failures++;
                $display("FAIL rand_%0d a=%h b=%h got c=%h r=%h lat=%0d busy_bad=%0d want c=%h r=%h",
                         i, a, b, c, r, lat, bb, ec, er);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] qc[$];
        logic [W-1:0] qr[$];
        logic [W-1:0] ec, er;
        logic exp_rdy, exp_busy;
        for (int t = 0; t <= 3 * LAT; t++) begin
            @(negedge clk);
            exp_rdy = (t > 0) && (t % LAT == 0);
            exp_busy = (t % LAT != 0);
            checks++;
            if (ready_out !== exp_rdy || busy_out !== exp_busy) begin
                failures++;
                $display("FAIL b2b_hs t=%0d got rdy=%b busy=%b want rdy=%b busy=%b",
                         t, ready_out, busy_out, exp_rdy, exp_busy);
            end
            if (exp_rdy && qc.size() > 0) begin
                ec = qc.pop_front();
                er = qr.pop_front();
                checks++;
                if (c_out !== ec || r_out !== er) begin
                    failures++;
                    $display("FAIL b2b_data t=%0d got c=%h r=%h want c=%h r=%h",
                             t, c_out, r_out, ec, er);
                end
            end
            a_in = $urandom;
            b_in = W'($urandom_range(0, 1000));
            start_in = (t < 3 * LAT);
            if (start_in && t % LAT == 0) begin
                ref_div(a_in, b_in, ec, er);
                qc.push_back(ec);
                qr.push_back(er);
            end
        end
        start_in = 1'b0;
        checks++;
        if (qc.size() != 0) begin
            failures++;
            $display("FAIL b2b_count got %0d results missing want 0", qc.size());
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] c, r;
        int lat, bb;
        int bad;
        @(negedge clk);
        a_in = $urandom;
        b_in = W'($urandom_range(1, 100));
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({c_out, r_out, ready_out, busy_out} !== '0) begin
            failures++;
            $display("FAIL abort_clear got c=%h r=%h rdy=%b busy=%b want all 0",
                     c_out, r_out, ready_out, busy_out);
        end
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (ready_out !== 1'b0 || busy_out !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL abort_stale got %0d active cycles want 0", bad);
        end
        run_op(32'd50, 32'd5, c, r, lat, bb);
        checks++;
        if (c !== 32'd10 || r !== 32'd0 || lat != LAT || bb != 0) begin
            failures++;
            $display("FAIL abort_next got c=%0d r=%0d lat=%0d busy_bad=%0d want c=10 r=0 lat=%0d",
                     c, r, lat, bb, LAT);
        end
    endtask

`ifdef AP_DIVI_SIGNED_EN
    task automatic test_signed();
        logic [W-1:0] ta [4] = '{-32'sd7, 32'sd7, 32'h8000_0000, -32'sd5};
        logic [W-1:0] tb [4] = '{32'sd2, -32'sd2, -32'sd1, 32'sd0};
        logic [W-1:0] tc [4] = '{-32'sd3, -32'sd3, 32'h8000_0000, 32'sd1};
        logic [W-1:0] tr [4] = '{-32'sd1, 32'sd1, 32'sd0, -32'sd5};
        logic [W-1:0] c, r;
        int lat, bb;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], c, r, lat, bb);
            checks++;
            if (c !== tc[i] || r !== tr[i] || lat != LAT) begin
                failures++;
                $display("FAIL signed_%0d got c=%h r=%h lat=%0d want c=%h r=%h",
                         i, c, r, lat, tc[i], tr[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_edges();
        test_random();
        test_back_to_back();
        test_abort();
`ifdef AP_DIVI_SIGNED_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
